// File: rtl/adder_display_pkg.sv
// Shared codes, FSM states and 7-segment constants for the adder/display controller.
package adder_display_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_CONV,
        ST_UPDT
    } state_e;

    // Active-low {dp, g, f, e, d, c, b, a}; DP is always held off (1).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Hex digit glyphs, entry 15 first so SEG_TBL[d] selects digit d.
    localparam logic [15:0][7:0] SEG_TBL = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        return SEG_TBL[d];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, RW steps per conversion.
module bin2bcd_seq #(
    parameter int RW = 5,
    parameter int ND = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [RW-1:0]        bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ND-1:0][3:0]   bcd_o
);
    localparam int CW = $clog2(RW + 1);

    logic [RW-1:0]      sh_q, sh_d;
    logic [ND-1:0][3:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // Load on start, otherwise correct each BCD nibble (>=5 -> +3) and shift {bcd, bin} left.
    always_comb begin
        adj    = '0;
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        for (int k = 0; k < ND; k++) begin
            adj[k] = (bcd_q[k] >= 4'd5) ? bcd_q[k] + 4'd3 : bcd_q[k];
        end
        if (start_i) begin
            sh_d   = bin_i;
            bcd_d  = '0;
            cnt_d  = CW'(RW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            {bcd_d, sh_d} = {adj, sh_q} << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    // Conversion state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done_o flags the cycle whose closing edge performs the final shift, so the
    // caller can leave its wait state on the same edge the result settles.
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/adder_display_ctrl.sv
// Registered add/subtract/accumulate unit with GO handshake and blanked 7-segment decimal output.
module adder_display_ctrl
    import adder_display_pkg::*;
#(
    parameter int W    = 4,
    parameter int NDIG = 3   // needs 10**(NDIG-1) > 2**(W+1)-1; top digit carries the sign
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [W-1:0]        A,
    input  logic [W-1:0]        B,
    input  logic [1:0]          OP,
    input  logic                GO,
    output logic                BUSY,
    output logic                DONE,
    output logic [W:0]          LED,
    output logic                NEG,
    output logic                OVF,
    output logic [8*NDIG-1:0]   HEX
);
    localparam int RW = W + 1;
    localparam int ND = NDIG - 1;

    state_e               state_q, state_d;
    logic                 go_s_q, go_q, go_edge, accept;
    logic [W-1:0]         a_q, b_q;
    logic [1:0]           op_q;
    logic [RW-1:0]        acc_q, acc_d, res_q, res_d;
    logic [RW:0]          acc_sum;
    logic                 negp_q, negp_d, ovfp_q, ovfp_d;
    logic                 busy_q, done_q, neg_q, ovf_q;
    logic [RW-1:0]        led_q;
    logic [NDIG-1:0][7:0] hex_q, hex_d;
    logic [NDIG-1:0][3:0] digs;
    logic                 nz;
    logic [ND-1:0][3:0]   conv_bcd;
    logic                 conv_start, conv_busy, conv_done;

    // GO is registered once before edge detection, so acceptance lands one edge
    // after the first edge that samples it high.
    assign go_edge    = go_s_q & ~go_q;
    assign accept     = (state_q == ST_IDLE) && go_edge;
    assign conv_start = (state_q == ST_CALC);

    // Next-state logic: IDLE -> CALC -> CONV (until converter finishes) -> UPDT -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go_edge) state_d = ST_CALC;
            ST_CALC: state_d = ST_CONV;
            ST_CONV: if (conv_done || !conv_busy) state_d = ST_UPDT;
            ST_UPDT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU: evaluated only in CALC; result, pending flags and ACC hold otherwise.
    always_comb begin
        res_d   = res_q;
        acc_d   = acc_q;
        negp_d  = negp_q;
        ovfp_d  = ovfp_q;
        acc_sum = {1'b0, acc_q} + (RW+1)'(a_q);
        if (state_q == ST_CALC) begin
            case (op_q)
                OP_ADD: begin
                    res_d  = RW'(a_q) + RW'(b_q);
                    negp_d = 1'b0;
                    ovfp_d = 1'b0;
                end
                OP_SUB: begin
                    res_d  = (a_q >= b_q) ? RW'(a_q - b_q) : RW'(b_q - a_q);
                    negp_d = (a_q < b_q);
                    ovfp_d = 1'b0;
                end
                OP_ACC: begin
                    res_d  = acc_sum[RW-1:0];
                    acc_d  = acc_sum[RW-1:0];
                    negp_d = 1'b0;
                    ovfp_d = acc_sum[RW];
                end
                default: begin // OP_CLR
                    res_d  = '0;
                    acc_d  = '0;
                    negp_d = 1'b0;
                    ovfp_d = 1'b0;
                end
            endcase
        end
    end

    // Display encode: blank leading zeros above digit 0, then overlay the minus sign.
    always_comb begin
        digs  = {4'h0, conv_bcd};
        hex_d = hex_q;
        nz    = 1'b0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            nz       = nz | (digs[k] != 4'h0);
            hex_d[k] = (k == 0 || nz) ? seg_of(digs[k]) : SEG_BLANK;
        end
        if (negp_q) hex_d[NDIG-1] = SEG_MINUS;
    end

    // State, operand latch, ACC and registered outputs; RST overrides any GO edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            go_s_q  <= 1'b1;
            go_q    <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            acc_q   <= '0;
            res_q   <= '0;
            negp_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            hex_q   <= {{ND{SEG_BLANK}}, seg_of(4'h0)};
        end else begin
            state_q <= state_d;
            go_s_q  <= GO;
            go_q    <= go_s_q;
            res_q   <= res_d;
            acc_q   <= acc_d;
            negp_q  <= negp_d;
            ovfp_q  <= ovfp_d;
            done_q  <= 1'b0;
            if (accept) begin
                a_q    <= A;
                b_q    <= B;
                op_q   <= OP;
                busy_q <= 1'b1;
            end
            if (state_q == ST_UPDT) begin
                led_q  <= res_q;
                neg_q  <= negp_q;
                ovf_q  <= ovfp_q;
                hex_q  <= hex_d;
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    bin2bcd_seq #(
        .RW (RW),
        .ND (ND)
    ) u_bin2bcd (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (conv_start),
        .bin_i   (res_d),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign LED  = led_q;
    assign NEG  = neg_q;
    assign OVF  = ovf_q;
    assign HEX  = hex_q;

endmodule
